// File: rtl/l1ca_acq_handoff.sv
// l1ca_acq_handoff: launches the L1 C/A fine search, qualifies its result
// against a power threshold with bounded retries, scales the Doppler bin
// into a carrier FCW with a sequential shift-add multiplier, and hands the
// initial NCO words to a tracking channel over valid/ready.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// LAUNCH    | one-cycle search_start pulse
// WAIT_RISE | waiting for the fine search to raise busy
// WAIT_FALL | waiting for busy to drop; result captured on the fall
// EVAL      | threshold / Doppler range test, retry decision
// MULT      | 8-cycle LSB-first shift-add of dop_idx * CARRIER_STEP
// HANDOFF   | trk_valid held until trk_ready
// FAILED    | one-cycle fail pulse
module l1ca_acq_handoff #(
    parameter int unsigned MAX_RETRY    = 2,
    parameter logic [31:0] CARRIER_BASE = 32'd898084362,
    parameter logic [15:0] CARRIER_STEP = 16'd11185,
    parameter logic [7:0]  MAX_DOP_IDX  = 8'd210,
    parameter int unsigned SV_W         = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SV_W-1:0] sv_in,
    input  logic            abort,
    input  logic [31:0]     threshold,
    output logic            search_start,
    output logic [SV_W-1:0] search_sv,
    input  logic            search_busy,
    input  logic [31:0]     search_acc,
    input  logic [12:0]     search_code_idx,
    input  logic [7:0]      search_dop_idx,
    output logic            trk_valid,
    input  logic            trk_ready,
    output logic [SV_W-1:0] trk_sv,
    output logic [31:0]     trk_carrier_fcw,
    output logic [9:0]      trk_code_chip,
    output logic [31:0]     trk_code_phase,
    output logic [15:0]     trk_doppler_hz,
    output logic            fail,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_RISE,
        WAIT_FALL,
        EVAL,
        MULT,
        HANDOFF,
        FAILED
    } state_t;

    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    state_t state_q, state_d;

    logic [SV_W-1:0] sv_q;
    logic [7:0]      retry_q;
    logic [31:0]     acc_q;
    logic [12:0]     code_q;
    logic [7:0]      dop_q;

    logic [23:0]     prod_q;
    logic [7:0]      dop_sh_q;
    logic [23:0]     step_sh_q;
    logic [2:0]      mult_cnt_q;

    logic [SV_W-1:0] trk_sv_q;
    logic [31:0]     trk_fcw_q;
    logic [9:0]      trk_chip_q;
    logic [31:0]     trk_phase_q;
    logic [15:0]     trk_hz_q;

    logic load_sv, clr_retry, inc_retry, capture, mult_load, mult_step, trk_load;
    logic eval_pass;

    logic [23:0] addend;
    logic [23:0] prod_sum;
    logic [31:0] fcw_sum;
    logic [15:0] dop_hz;

    assign eval_pass = (acc_q > threshold) && (dop_q <= MAX_DOP_IDX);

    // Partial product for the current iteration; the final iteration's sum
    // feeds the FCW directly so HANDOFF is entered with the finished word.
    assign addend   = dop_sh_q[0] ? step_sh_q : 24'd0;
    assign prod_sum = prod_q + addend;
    assign fcw_sum  = CARRIER_BASE + {8'd0, prod_sum};
    // Modulo-2^16 arithmetic yields the correct two's-complement result.
    assign dop_hz   = ({8'd0, dop_q} * 16'd50) - 16'd5250;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        load_sv   = 1'b0;
        clr_retry = 1'b0;
        inc_retry = 1'b0;
        capture   = 1'b0;
        mult_load = 1'b0;
        mult_step = 1'b0;
        trk_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_sv   = 1'b1;
                    clr_retry = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH:    state_d = WAIT_RISE;
            WAIT_RISE: if (search_busy) state_d = WAIT_FALL;
            WAIT_FALL: begin
                if (!search_busy) begin
                    capture = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (eval_pass) begin
                    mult_load = 1'b1;
                    state_d   = MULT;
                end else if (retry_q < RETRY_LIM) begin
                    inc_retry = 1'b1;
                    state_d   = LAUNCH;
                end else begin
                    state_d = FAILED;
                end
            end
            MULT: begin
                mult_step = 1'b1;
                if (mult_cnt_q == 3'd7) begin
                    trk_load = 1'b1;
                    state_d  = HANDOFF;
                end
            end
            HANDOFF:   if (trk_ready) state_d = IDLE;
            FAILED:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            load_sv   = 1'b0;
            clr_retry = 1'b0;
            inc_retry = 1'b0;
            capture   = 1'b0;
            mult_load = 1'b0;
            mult_step = 1'b0;
            trk_load  = 1'b0;
        end
    end

    // Request context, retry count and captured search result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q    <= '0;
            retry_q <= 8'd0;
            acc_q   <= 32'd0;
            code_q  <= 13'd0;
            dop_q   <= 8'd0;
        end else begin
            if (load_sv) sv_q <= sv_in;
            if (clr_retry) retry_q <= 8'd0;
            else if (inc_retry) retry_q <= retry_q + 8'd1;
            if (capture) begin
                acc_q  <= search_acc;
                code_q <= search_code_idx;
                dop_q  <= search_dop_idx;
            end
        end
    end

    // Shift-add multiplier: multiplicand shifts left, multiplier bits right.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= 24'd0;
            dop_sh_q   <= 8'd0;
            step_sh_q  <= 24'd0;
            mult_cnt_q <= 3'd0;
        end else if (mult_load) begin
            prod_q     <= 24'd0;
            dop_sh_q   <= dop_q;
            step_sh_q  <= {8'd0, CARRIER_STEP};
            mult_cnt_q <= 3'd0;
        end else if (mult_step) begin
            prod_q     <= prod_sum;
            dop_sh_q   <= {1'b0, dop_sh_q[7:1]};
            step_sh_q  <= {step_sh_q[22:0], 1'b0};
            mult_cnt_q <= mult_cnt_q + 3'd1;
        end
    end

    // Tracking handoff words, loaded only on entry to HANDOFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_sv_q    <= '0;
            trk_fcw_q   <= 32'd0;
            trk_chip_q  <= 10'd0;
            trk_phase_q <= 32'd0;
            trk_hz_q    <= 16'd0;
        end else if (trk_load) begin
            trk_sv_q    <= sv_q;
            trk_fcw_q   <= fcw_sum;
            trk_chip_q  <= code_q[12:3];
            trk_phase_q <= {code_q[2:0], 29'd0};
            trk_hz_q    <= dop_hz;
        end
    end

    assign search_start    = (state_q == LAUNCH);
    assign search_sv       = sv_q;
    assign trk_valid       = (state_q == HANDOFF);
    assign fail            = (state_q == FAILED);
    assign busy            = (state_q != IDLE);
    assign trk_sv          = trk_sv_q;
    assign trk_carrier_fcw = trk_fcw_q;
    assign trk_code_chip   = trk_chip_q;
    assign trk_code_phase  = trk_phase_q;
    assign trk_doppler_hz  = trk_hz_q;

endmodule

// File: tb/tb_l1ca_acq_handoff.sv
// Bench for l1ca_acq_handoff: emulates the fine search and checks handoff
// words against arithmetic derived directly from the bin/index definitions.
module tb_l1ca_acq_handoff;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  sv_in;
    logic        abort;
    logic [31:0] threshold;
    logic        search_start;
    logic [5:0]  search_sv;
    logic        search_busy;
    logic [31:0] search_acc;
    logic [12:0] search_code_idx;
    logic [7:0]  search_dop_idx;
    logic        trk_valid;
    logic        trk_ready;
    logic [5:0]  trk_sv;
    logic [31:0] trk_carrier_fcw;
    logic [9:0]  trk_code_chip;
    logic [31:0] trk_code_phase;
    logic [15:0] trk_doppler_hz;
    logic        fail;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    l1ca_acq_handoff dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .sv_in           (sv_in),
        .abort           (abort),
        .threshold       (threshold),
        .search_start    (search_start),
        .search_sv       (search_sv),
        .search_busy     (search_busy),
        .search_acc      (search_acc),
        .search_code_idx (search_code_idx),
        .search_dop_idx  (search_dop_idx),
        .trk_valid       (trk_valid),
        .trk_ready       (trk_ready),
        .trk_sv          (trk_sv),
        .trk_carrier_fcw (trk_carrier_fcw),
        .trk_code_chip   (trk_code_chip),
        .trk_code_phase  (trk_code_phase),
        .trk_doppler_hz  (trk_doppler_hz),
        .fail            (fail),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (search_start) n_start <= n_start + 1;
        if (fail)         n_fail  <= n_fail + 1;
        if (trk_valid)    n_valid <= n_valid + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_fcw(input logic [7:0] d);
        return 32'd898084362 + 32'(d) * 32'd11185;
    endfunction

    function automatic logic [15:0] ref_hz(input logic [7:0] d);
        int v;
        v = int'(d) * 50 - 5250;
        return 16'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [5:0] sv);
        sv_in = sv;
        start = 1'b1;
        tick();
        start = 1'b0;
        sv_in = 6'($urandom);
    endtask

    // Emulates one fine search; returns the cycle in which busy is seen low.
    // Leaves the bench one cycle later (the DUT's EVAL cycle).
    task automatic search(input logic [7:0] dop, input logic [12:0] code,
                          input logic [31:0] acc, output int t);
        for (int i = 0; i < 40 && !search_start; i++) tick();
        check("launch_seen", search_start, 1);
        tick();
        repeat ($urandom_range(0, 2)) tick();
        search_busy     = 1'b1;
        search_acc      = $urandom;
        search_code_idx = 13'($urandom);
        search_dop_idx  = 8'($urandom);
        repeat ($urandom_range(1, 4)) tick();
        search_busy     = 1'b0;
        search_acc      = acc;
        search_code_idx = code;
        search_dop_idx  = dop;
        t = cyc;
        tick();
    endtask

    task automatic expect_pass(input int t, input logic [5:0] sv,
                               input logic [7:0] dop, input logic [12:0] code);
        while (cyc < t + 9) tick();
        check("valid_early", trk_valid, 0);
        tick();
        check("valid_at_t10", trk_valid, 1);
        check("trk_fcw", trk_carrier_fcw, ref_fcw(dop));
        check("trk_chip", trk_code_chip, code / 8);
        check("trk_phase", trk_code_phase, 64'(code % 8) << 29);
        check("trk_hz", trk_doppler_hz, ref_hz(dop));
        check("trk_sv", trk_sv, sv);
    endtask

    task automatic fail_all(input logic [7:0] dop, input logic [31:0] acc, input string tag);
        int t;
        int s0;
        int f0;
        s0 = n_start;
        f0 = n_fail;
        launch(6'd9);
        for (int a = 0; a < 3; a++) begin
            search(dop, 13'($urandom_range(0, 8183)), acc, t);
            tick();
            if (a < 2) check({tag, "_relaunch"}, search_start, 1);
            else       check({tag, "_fail_pulse"}, fail, 1);
        end
        tick();
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_starts"}, n_start - s0, 3);
        check({tag, "_fails"}, n_fail - f0, 1);
    endtask

    initial begin
        int t;
        int s0;
        int f0;
        int v0;
        logic [7:0]  d;
        logic [12:0] c;
        logic [5:0]  s;
        logic [31:0] last_fcw;

        rst = 1'b1; start = 1'b0; sv_in = 6'd0; abort = 1'b0;
        threshold = 32'd1000; search_busy = 1'b0; search_acc = 32'd0;
        search_code_idx = 13'd0; search_dop_idx = 8'd0; trk_ready = 1'b1;
        repeat (3) tick();
        check("rst_search_start", search_start, 0);
        check("rst_trk_valid", trk_valid, 0);
        check("rst_fail", fail, 0);
        check("rst_busy", busy, 0);
        check("rst_fcw", trk_carrier_fcw, 0);
        check("rst_chip", trk_code_chip, 0);
        check("rst_phase", trk_code_phase, 0);
        check("rst_hz", trk_doppler_hz, 0);
        check("rst_sv", trk_sv, 0);
        check("rst_search_sv", search_sv, 0);
        rst = 1'b0;
        tick();

        // Reference vector from the block description.
        s0 = n_start;
        launch(6'd17);
        check("start_to_launch", search_start, 1);
        check("search_sv", search_sv, 17);
        search(8'd105, 13'd4097, 32'd5000, t);
        expect_pass(t, 6'd17, 8'd105, 13'd4097);
        check("ref_fcw_const", trk_carrier_fcw, 32'd899258787);
        check("ref_hz_zero", trk_doppler_hz, 0);
        tick();
        check("handoff_one_cycle", trk_valid, 0);
        check("idle_after", busy, 0);
        check("ref_starts", n_start - s0, 1);

        // Doppler range endpoints.
        launch(6'd3);
        search(8'd0, 13'd0, 32'd1001, t);
        expect_pass(t, 6'd3, 8'd0, 13'd0);
        check("dop0_fcw", trk_carrier_fcw, 32'd898084362);
        check("dop0_hz", trk_doppler_hz, 16'hEB7E);
        tick();
        launch(6'd31);
        search(8'd210, 13'd8183, 32'hFFFF_FFFF, t);
        expect_pass(t, 6'd31, 8'd210, 13'd8183);
        check("dop210_fcw", trk_carrier_fcw, 32'd900433212);
        check("dop210_hz", trk_doppler_hz, 16'd5250);
        tick();

        // Randomized passing acquisitions.
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 210));
            c = 13'($urandom_range(0, 8183));
            s = 6'($urandom);
            threshold = $urandom_range(0, 32'h7FFF_FFFF);
            launch(s);
            search(d, c, threshold + 32'($urandom_range(1, 1000)), t);
            expect_pass(t, s, d, c);
            tick();
            check("rand_idle", busy, 0);
        end

        // Equality on every attempt, then out-of-range Doppler with high power.
        threshold = 32'd1000;
        fail_all(8'd50, 32'd1000, "eq");
        fail_all(8'd211, 32'hFFFF_FFFF, "dop211");

        // First attempt below, second above.
        s0 = n_start;
        launch(6'd22);
        search(8'd7, 13'd100, 32'd995, t);
        tick();
        check("retry_relaunch", search_start, 1);
        search(8'd190, 13'd6001, 32'd1009, t);
        expect_pass(t, 6'd22, 8'd190, 13'd6001);
        tick();
        check("retry_starts", n_start - s0, 2);

        // Ready stall.
        trk_ready = 1'b0;
        launch(6'd12);
        search(8'd77, 13'd3333, 32'd2000, t);
        expect_pass(t, 6'd12, 8'd77, 13'd3333);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_valid", trk_valid, 1);
            check("stall_fcw", trk_carrier_fcw, ref_fcw(8'd77));
            check("stall_hz", trk_doppler_hz, ref_hz(8'd77));
        end
        trk_ready = 1'b1;
        tick();
        check("stall_release", trk_valid, 0);
        check("stall_idle", busy, 0);
        last_fcw = ref_fcw(8'd77);

        // Abort during WAIT_FALL.
        f0 = n_fail; v0 = n_valid;
        launch(6'd5);
        tick();
        search_busy = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_wf_idle", busy, 0);
        search_busy = 1'b0;
        search_acc = 32'd99999; search_dop_idx = 8'd10; search_code_idx = 13'd10;
        repeat (12) tick();
        check("abort_wf_no_valid", n_valid - v0, 0);
        check("abort_wf_no_fail", n_fail - f0, 0);
        check("abort_wf_busy", busy, 0);

        // Abort during MULT together with start.
        s0 = n_start; f0 = n_fail; v0 = n_valid;
        launch(6'd6);
        search(8'd150, 13'd777, 32'd5000, t);
        repeat (3) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_mult_idle", busy, 0);
        check("abort_mult_no_launch", search_start, 0);
        repeat (15) tick();
        check("abort_mult_no_valid", n_valid - v0, 0);
        check("abort_mult_no_fail", n_fail - f0, 0);
        check("abort_mult_starts", n_start - s0, 1);
        check("abort_mult_fcw_held", trk_carrier_fcw, last_fcw);

        // Normal run after aborts.
        launch(6'd29);
        search(8'd33, 13'd1234, 32'd1500, t);
        expect_pass(t, 6'd29, 8'd33, 13'd1234);
        tick();
        check("post_abort_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
